// File: rtl/per2apb_pkg.sv
// Shared types and constants for the peripheral-to-APB bridge.
package per2apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic PER_OPC_OK  = 1'b0;
    localparam logic PER_OPC_ERR = 1'b1;

    localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/per2apb.sv
// Peripheral request/response port to APB master bridge, one transaction at a time.
// Partial writes are rejected with an error response because APB carries no byte strobes.
module per2apb
    import per2apb_pkg::*;
#(
    parameter int PER_ADDR_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int ID_WIDTH       = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      per_slave_req_i,
    input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
    input  logic                      per_slave_we_i,
    input  logic [31:0]               per_slave_wdata_i,
    input  logic [3:0]                per_slave_be_i,
    input  logic [ID_WIDTH-1:0]       per_slave_id_i,
    output logic                      per_slave_gnt_o,
    output logic                      per_slave_r_valid_o,
    output logic                      per_slave_r_opc_o,
    output logic [ID_WIDTH-1:0]       per_slave_r_id_o,
    output logic [31:0]               per_slave_r_rdata_o,

    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e state_reg;
    state_e state_next;

    logic [PER_ADDR_WIDTH-1:0] addr_reg;
    logic                      we_reg;
    logic [31:0]               wdata_reg;
    logic [ID_WIDTH-1:0]       id_reg;
    logic [CNT_W-1:0]          wait_cnt_reg;

    logic                      r_opc_reg;
    logic [ID_WIDTH-1:0]       r_id_reg;
    logic [31:0]               r_rdata_reg;

    logic accept;
    logic partial_wr;
    logic apb_done;
    logic apb_timeout;

    // The byte enables only matter for the accept-time decision, so they are not kept.
    assign accept      = per_slave_req_i && (state_reg == IDLE);
    assign partial_wr  = per_slave_we_i && (per_slave_be_i != BE_FULL);
    assign apb_done    = (state_reg == ACCESS) && PREADY;
    assign apb_timeout = (state_reg == ACCESS) && !PREADY && (wait_cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = partial_wr ? RESP : SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (apb_done || apb_timeout) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        per_slave_gnt_o     = accept;
        per_slave_r_valid_o = (state_reg == RESP);
        per_slave_r_opc_o   = r_opc_reg;
        per_slave_r_id_o    = r_id_reg;
        per_slave_r_rdata_o = r_rdata_reg;
        PSEL                = (state_reg == SETUP) || (state_reg == ACCESS);
        PENABLE             = (state_reg == ACCESS);
        PWRITE              = we_reg;
        PWDATA              = wdata_reg;
        PADDR               = APB_ADDR_WIDTH'(addr_reg & ~(PER_ADDR_WIDTH'(3)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg     <= '0;
            we_reg       <= 1'b0;
            wdata_reg    <= '0;
            id_reg       <= '0;
            wait_cnt_reg <= '0;
            r_opc_reg    <= PER_OPC_OK;
            r_id_reg     <= '0;
            r_rdata_reg  <= '0;
        end else begin
            if (accept) begin
                addr_reg  <= per_slave_add_i;
                we_reg    <= per_slave_we_i;
                wdata_reg <= per_slave_wdata_i;
                id_reg    <= per_slave_id_i;
            end

            if (state_reg == SETUP) begin
                wait_cnt_reg <= '0;
            end else if ((state_reg == ACCESS) && !PREADY && !apb_timeout) begin
                wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
            end

            // Response fields only move on the edge that enters RESP.
            if (accept && partial_wr) begin
                r_opc_reg   <= PER_OPC_ERR;
                r_rdata_reg <= '0;
                r_id_reg    <= per_slave_id_i;
            end else if (apb_done) begin
                r_opc_reg   <= PSLVERR;
                r_rdata_reg <= we_reg ? 32'h0 : PRDATA;
                r_id_reg    <= id_reg;
            end else if (apb_timeout) begin
                r_opc_reg   <= PER_OPC_ERR;
                r_rdata_reg <= '0;
                r_id_reg    <= id_reg;
            end
        end
    end

endmodule

// File: tb/tb_per2apb.sv
// Randomised scoreboard bench for per2apb with an APB slave model and a response monitor.
module tb_per2apb;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] add = '0;
    logic        we = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic [4:0]  id = '0;
    logic        gnt;
    logic        r_valid;
    logic        r_opc;
    logic [4:0]  r_id;
    logic [31:0] r_rdata;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    per2apb #(
        .PER_ADDR_WIDTH(32),
        .APB_ADDR_WIDTH(32),
        .ID_WIDTH(5),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .per_slave_req_i(req),
        .per_slave_add_i(add),
        .per_slave_we_i(we),
        .per_slave_wdata_i(wdata),
        .per_slave_be_i(be),
        .per_slave_id_i(id),
        .per_slave_gnt_o(gnt),
        .per_slave_r_valid_o(r_valid),
        .per_slave_r_opc_o(r_opc),
        .per_slave_r_id_o(r_id),
        .per_slave_r_rdata_o(r_rdata),
        .PADDR(PADDR),
        .PWDATA(PWDATA),
        .PWRITE(PWRITE),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        opc;
        logic [4:0]  id;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    typedef struct {
        logic [31:0] paddr;
        logic        we;
        logic [31:0] wdata;
        int          waits;
        logic        err;
        logic [31:0] rdata;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: outcome and latency follow directly from the transfer's rules.
    function automatic exp_t model(input logic w, input logic [3:0] b, input logic [4:0] tid,
                                   input int waits, input logic err, input logic [31:0] prd,
                                   input int gcyc);
        exp_t e;
        e.id = tid;
        if (w && b != 4'hF) begin
            e.opc = 1'b1; e.rdata = 32'h0; e.due = gcyc + 1;
        end else if (waits >= TO) begin
            e.opc = 1'b1; e.rdata = 32'h0; e.due = gcyc + 2 + TO;
        end else begin
            e.opc = err; e.rdata = w ? 32'h0 : prd; e.due = gcyc + 3 + waits;
        end
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after the grant.
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [3:0] b, input logic [4:0] tid, input int waits,
                         input logic err, input logic [31:0] prd);
        bit got = 0;
        req = 1'b1; add = a; we = w; wdata = wd; be = b; id = tid;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (gnt) got = 1;
            else begin @(posedge clk); #1; end
        end
        chk("grant_seen", 64'(got), 64'd1);
        if (got) begin
            exp_q.push_back(model(w, b, tid, waits, err, prd, cyc));
            if (!(w && b != 4'hF))
                plan_q.push_back('{paddr: a & ~32'h3, we: w, wdata: wd, waits: waits,
                                   err: err, rdata: prd});
        end
        @(posedge clk); #1;
        req = 1'b0; add = $urandom; we = 1'($urandom_range(0, 1)); wdata = $urandom;
        be = 4'($urandom); id = 5'($urandom);
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
    endtask

    // APB slave model: stalls for the planned number of wait states.
    plan_t cur;
    int    acc_n = 0;
    bit    active = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            plan_q.delete();
            active = 0;
            PREADY = 1'b0;
        end else if (PSEL && !PENABLE) begin
            if (plan_q.size() == 0) flag("unexpected_setup");
            else begin
                cur = plan_q.pop_front();
                active = 1;
                acc_n = 0;
                chk("setup_paddr", 64'(PADDR), 64'(cur.paddr));
                chk("setup_pwrite", 64'(PWRITE), 64'(cur.we));
                chk("setup_pwdata", 64'(PWDATA), 64'(cur.wdata));
            end
            PREADY = 1'b0;
        end else if (PSEL && PENABLE) begin
            chk("access_paddr", 64'(PADDR), 64'(cur.paddr));
            chk("access_pwdata", 64'(PWDATA), 64'(cur.wdata));
            chk("access_pwrite", 64'(PWRITE), 64'(cur.we));
            PREADY  = (acc_n == cur.waits);
            PRDATA  = cur.rdata;
            PSLVERR = cur.err;
            acc_n++;
        end else begin
            if (active) begin
                chk("access_cycles", 64'(acc_n), 64'((cur.waits < TO) ? cur.waits + 1 : TO));
                active = 0;
            end
            chk("penable_without_psel", 64'(PENABLE), 64'd0);
            PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
        end
    end

    // Response monitor: pops the scoreboard on every r_valid.
    logic        last_opc = 1'b0;
    logic [4:0]  last_id = '0;
    logic [31:0] last_rdata = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            last_opc = 1'b0; last_id = '0; last_rdata = '0;
        end else begin
            if (r_valid) begin
                if (exp_q.size() == 0) flag("unexpected_response");
                else begin
                    e = exp_q.pop_front();
                    chk("resp_opc", 64'(r_opc), 64'(e.opc));
                    chk("resp_id", 64'(r_id), 64'(e.id));
                    chk("resp_rdata", 64'(r_rdata), 64'(e.rdata));
                    chk("resp_cycle", 64'(cyc), 64'(e.due));
                    $display("resp id=%0d opc=%0d rdata=%08h cycle=%0d", r_id, r_opc, r_rdata, cyc);
                end
                last_opc = r_opc; last_id = r_id; last_rdata = r_rdata;
            end else begin
                chk("resp_hold", {r_opc, r_id, r_rdata}, {last_opc, last_id, last_rdata});
            end
            if (gnt) chk("gnt_only_idle", 64'({PSEL, r_valid}), 64'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        logic [3:0] b;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_psel", 64'(PSEL), 64'd0);
        chk("rst_penable", 64'(PENABLE), 64'd0);
        chk("rst_pwrite", 64'(PWRITE), 64'd0);
        chk("rst_paddr", 64'(PADDR), 64'd0);
        chk("rst_pwdata", 64'(PWDATA), 64'd0);
        chk("rst_resp", {r_valid, r_opc, r_id, r_rdata}, 64'd0);
        rst_n = 1'b1;
        gap(1);

        // Zero-wait read, 3-wait write, slave error, timeout, partial write, PREADY on last count.
        issue(32'h1A10_7004, 1'b0, 32'h0, 4'hF, 5'd3, 0, 1'b0, 32'hCAFE_0001);
        gap(1);
        issue(32'h1A10_7008, 1'b1, 32'h0000_00A5, 4'hF, 5'd7, 3, 1'b0, 32'h1234_5678);
        gap(1);
        issue(32'h2000_0013, 1'b0, 32'h0, 4'hF, 5'd9, 1, 1'b1, 32'hDEAD_BEEF);
        gap(1);
        issue(32'h3000_0000, 1'b0, 32'h0, 4'hF, 5'd11, 20, 1'b0, 32'h5555_AAAA);
        gap(1);
        issue(32'h4000_0004, 1'b1, 32'hFFFF_0000, 4'h3, 5'd13, 0, 1'b0, 32'h0);
        issue(32'h5000_0008, 1'b0, 32'h0, 4'hF, 5'd17, TO - 1, 1'b0, 32'h0BAD_F00D);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 9))
                6: waits = TO - 1;
                7: waits = TO;
                8: waits = 15;
                default: waits = int'($urandom_range(0, 3));
            endcase
            b = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
            issue($urandom, 1'($urandom_range(0, 1)), $urandom, b, 5'($urandom), waits,
                  1'($urandom_range(0, 3) == 0), $urandom);
            gap(int'($urandom_range(0, 2)));
        end

        // Reset during ACCESS aborts the transfer with no response.
        gap(30);
        issue(32'h6000_0010, 1'b0, 32'h0, 4'hF, 5'd21, 20, 1'b0, 32'h7777_7777);
        for (int n = 0; n < 10 && !PENABLE; n++) @(negedge clk);
        @(negedge clk);
        chk("mid_reached_access", 64'(PENABLE), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_psel", 64'(PSEL), 64'd0);
        chk("mid_rst_penable", 64'(PENABLE), 64'd0);
        chk("mid_rst_resp", {r_valid, r_opc, r_id, r_rdata}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        gap(3);
        issue(32'h7000_0024, 1'b0, 32'h0, 4'hF, 5'd25, 2, 1'b0, 32'hA5A5_5A5A);

        gap(30);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        chk("plans_drained", 64'(plan_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
